// File: rtl/homography_warp.sv
// rtl/homography_warp.sv - inverse-mapping 3x3 homography with sequential divide and SRAM fetch.
// Define HOMOGRAPHY_ROUND_EN for round-half-away-from-zero instead of truncation.
module homography_warp #(
   parameter int          XY_W     = 10,
   parameter int          COEF_W   = 12,
   parameter int          IMG_W    = 640,
   parameter int          IMG_H    = 480,
   parameter logic [15:0] FILL_RGB = 16'h0
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iCOEF_WE,
   input  logic [3:0]        iCOEF_ADDR,
   input  logic [COEF_W-1:0] iCOEF_DATA,
   input  logic              iSTART,
   input  logic [XY_W-1:0]   iX,
   input  logic [XY_W-1:0]   iY,
   output logic              oBUSY,
   output logic              oREQ,
   output logic [XY_W-1:0]   oSRAM_X,
   output logic [XY_W-1:0]   oSRAM_Y,
   input  logic              iREADY,
   input  logic [4:0]        iR,
   input  logic [5:0]        iG,
   input  logic [4:0]        iB,
   output logic [XY_W-1:0]   oCON_X,
   output logic [XY_W-1:0]   oCON_Y,
   output logic [4:0]        oR,
   output logic [5:0]        oG,
   output logic [4:0]        oB,
   output logic              oREADY,
   output logic              oOOB
);

   localparam int ACC_W = COEF_W + XY_W + 3;
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam logic [ACC_W-1:0] LIM_X = ACC_W'(IMG_W);
   localparam logic [ACC_W-1:0] LIM_Y = ACC_W'(IMG_H);

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_DIV, S_CHK, S_REQ, S_WAIT, S_OUT} state_t;

   state_t                    r_state;
   logic signed [COEF_W-1:0]  r_h [9];
   logic signed [ACC_W-1:0]   r_nx, r_ny, r_d;
   logic [ACC_W-1:0]          r_dm, r_qx, r_qy, r_rx, r_ry;
   logic                      r_negx, r_negy, r_dz;
   logic [CNT_W-1:0]          r_cnt;

   logic signed [ACC_W-1:0]   w_x, w_y, w_nx, w_ny, w_d;
   logic [ACC_W-1:0]          w_ad, w_mx, w_my;
   logic                      w_oob;

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [COEF_W-1:0] c);
      return {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
   endfunction

   function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
   endfunction

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   function automatic logic [2*ACC_W-1:0] div_step(input logic [ACC_W-1:0] rem,
                                                   input logic [ACC_W-1:0] quo,
                                                   input logic [ACC_W-1:0] den);
      logic [ACC_W:0] t;
      t = {rem, quo[ACC_W-1]};
      if (t >= {1'b0, den})
         return {t[ACC_W-1:0] - den, quo[ACC_W-2:0], 1'b1};
      else
         return {t[ACC_W-1:0], quo[ACC_W-2:0], 1'b0};
   endfunction

   assign w_x  = $signed(ACC_W'(oCON_X));
   assign w_y  = $signed(ACC_W'(oCON_Y));
   assign w_nx = sext(r_h[0]) * w_x + sext(r_h[1]) * w_y + sext(r_h[2]);
   assign w_ny = sext(r_h[3]) * w_x + sext(r_h[4]) * w_y + sext(r_h[5]);
   assign w_d  = sext(r_h[6]) * w_x + sext(r_h[7]) * w_y + sext(r_h[8]);
   assign w_ad = mag(r_d);

`ifdef HOMOGRAPHY_ROUND_EN
   assign w_mx = mag(r_nx) + (w_ad >> 1);
   assign w_my = mag(r_ny) + (w_ad >> 1);
`else
   assign w_mx = mag(r_nx);
   assign w_my = mag(r_ny);
`endif

   // A negative quotient that truncated to zero is still a valid coordinate.
   assign w_oob = r_dz || (r_negx && (r_qx != '0)) || (r_negy && (r_qy != '0)) ||
                  (r_qx >= LIM_X) || (r_qy >= LIM_Y);

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state <= S_IDLE;
         for (int i = 0; i < 9; i++)
            r_h[i] <= (i == 0 || i == 4 || i == 8) ? COEF_W'(1) : '0;
         r_nx    <= '0;
         r_ny    <= '0;
         r_d     <= '0;
         r_dm    <= '0;
         r_qx    <= '0;
         r_qy    <= '0;
         r_rx    <= '0;
         r_ry    <= '0;
         r_negx  <= 1'b0;
         r_negy  <= 1'b0;
         r_dz    <= 1'b0;
         r_cnt   <= '0;
         oBUSY   <= 1'b0;
         oREQ    <= 1'b0;
         oSRAM_X <= '0;
         oSRAM_Y <= '0;
         oCON_X  <= '0;
         oCON_Y  <= '0;
         oR      <= '0;
         oG      <= '0;
         oB      <= '0;
         oREADY  <= 1'b0;
         oOOB    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iCOEF_WE) begin
                  for (int i = 0; i < 9; i++)
                     if (iCOEF_ADDR == 4'(i))
                        r_h[i] <= iCOEF_DATA;
               end
               if (iSTART) begin
                  oCON_X  <= iX;
                  oCON_Y  <= iY;
                  oBUSY   <= 1'b1;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_nx    <= w_nx;
               r_ny    <= w_ny;
               r_d     <= w_d;
               r_cnt   <= '0;
               r_state <= S_DIV;
            end
            S_DIV: begin
               // First DIV cycle loads magnitudes; the remaining ACC_W cycles are divide steps.
               if (r_cnt == '0) begin
                  r_dm   <= w_ad;
                  r_qx   <= w_mx;
                  r_qy   <= w_my;
                  r_rx   <= '0;
                  r_ry   <= '0;
                  r_negx <= r_nx[ACC_W-1] ^ r_d[ACC_W-1];
                  r_negy <= r_ny[ACC_W-1] ^ r_d[ACC_W-1];
                  r_dz   <= (r_d == '0);
               end else begin
                  {r_rx, r_qx} <= div_step(r_rx, r_qx, r_dm);
                  {r_ry, r_qy} <= div_step(r_ry, r_qy, r_dm);
               end
               if (r_cnt == CNT_W'(ACC_W))
                  r_state <= S_CHK;
               r_cnt <= r_cnt + 1'b1;
            end
            S_CHK: begin
               if (w_oob) begin
                  oOOB         <= 1'b1;
                  oREADY       <= 1'b1;
                  {oR, oG, oB} <= FILL_RGB;
                  r_state      <= S_OUT;
               end else begin
                  oOOB    <= 1'b0;
                  oSRAM_X <= r_qx[XY_W-1:0];
                  oSRAM_Y <= r_qy[XY_W-1:0];
                  oREQ    <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               oREQ    <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (iREADY) begin
                  oR      <= iR;
                  oG      <= iG;
                  oB      <= iB;
                  oREADY  <= 1'b1;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               oREADY  <= 1'b0;
               oBUSY   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
